ifetch_stage: RTL and testbench

Instruction-fetch stage of the DLX pipeline, downstream of the PC unit. Captures the PC unit's `NextPC`, issues it to instruction SRAM over a req/ack handshake tolerating variable memory latency, and presents the fetched instruction with its PC and PC+4 to the ID stage. Back-pressures the PC unit via `fetch_stall` while memory is busy or ID is stalled. Squashes wrong-path fetches on a taken branch.

---
 rtl/ifetch_stage.sv | 152 +++++++++++++++
 tb/tb_ifetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// DLX instruction-fetch stage: launches NextPC to instruction SRAM over req/ack,
// buffers one instruction under ID stall, and squashes wrong-path fetches on branch.
module ifetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        branch,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_addr, fetch_addr_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        squash, squash_nxt;
  logic [31:0] hb_instr, hb_instr_nxt;
  logic [31:0] hb_pc, hb_pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc_nxt;
  logic        valid_nxt;
  logic        accept;

  // req_addr is the address of the outstanding request; it differs from
  // fetch_addr only while a squashed fetch is still waiting for its ack.
  assign imem_addr   = req_addr;
  assign imem_req    = (state == REQ);
  assign accept      = (state == REQ) && imem_ack && !squash && !branch;
  assign fetch_stall = reset || !accept;

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    req_addr_nxt   = req_addr;
    squash_nxt     = squash;
    hb_instr_nxt   = hb_instr;
    hb_pc_nxt      = hb_pc;
    instr_nxt      = if_instr;
    pc_nxt         = if_pc;
    valid_nxt      = if_valid;

    // ID consumed the current word; show a bubble unless something new loads.
    if (!stall) begin
      valid_nxt = 1'b0;
      instr_nxt = NOP_INSTR;
    end else begin
      valid_nxt = if_valid;
    end

    case (state)
      IDLE: begin
        state_nxt      = REQ;
        fetch_addr_nxt = RESET_PC;
        req_addr_nxt   = RESET_PC;
      end
      REQ: begin
        if (imem_ack) begin
          if (squash || branch) begin
            squash_nxt     = 1'b0;
            fetch_addr_nxt = pc_in;
          end else begin
            fetch_addr_nxt = pc_in + 32'd4;
            if (!stall || !if_valid) begin
              instr_nxt = imem_rdata;
              pc_nxt    = req_addr;
              valid_nxt = 1'b1;
            end else begin
              hb_instr_nxt = imem_rdata;
              hb_pc_nxt    = req_addr;
              state_nxt    = FULL;
            end
          end
          req_addr_nxt = fetch_addr_nxt;
        end else begin
          req_addr_nxt = req_addr;
        end
      end
      FULL: begin
        if (!stall) begin
          instr_nxt = hb_instr;
          pc_nxt    = hb_pc;
          valid_nxt = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = FULL;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything; an unacked request keeps its address
    // on the bus and is flagged for discard.
    if (branch) begin
      valid_nxt      = 1'b0;
      instr_nxt      = NOP_INSTR;
      fetch_addr_nxt = pc_in;
      state_nxt      = REQ;
      if ((state == REQ) && !imem_ack) begin
        squash_nxt   = 1'b1;
        req_addr_nxt = req_addr;
      end else begin
        squash_nxt   = 1'b0;
        req_addr_nxt = pc_in;
      end
    end else begin
      squash_nxt = squash_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      req_addr   <= RESET_PC;
      squash     <= 1'b0;
      hb_instr   <= NOP_INSTR;
      hb_pc      <= 32'd0;
      if_instr   <= NOP_INSTR;
      if_pc      <= 32'd0;
      if_pc4     <= 32'd4;
      if_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      req_addr   <= req_addr_nxt;
      squash     <= squash_nxt;
      hb_instr   <= hb_instr_nxt;
      hb_pc      <= hb_pc_nxt;
      if_instr   <= instr_nxt;
      if_pc      <= pc_nxt;
      if_pc4     <= pc_nxt + 32'd4;
      if_valid   <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: SRAM model with programmable wait states
// (addr-as-data) and a PC unit that advances when fetch_stall is low.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in;
  logic        branch = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        fetch_stall;

  int          wait_n = 0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
  logic        mem_ack;
  logic [31:0] pc_model = 32'd0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  ifetch_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .branch(branch), .stall(stall),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .if_valid(if_valid), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  assign mem_ack    = imem_req && (cnt == wait_n);
  assign imem_ack   = mem_ack || force_ack;
  assign imem_rdata = imem_addr;
  assign pc_in      = branch ? br_target : pc_model;

  always @(posedge clk) begin
    cnt <= (imem_req && !mem_ack) ? cnt + 1 : 0;
    if (reset) pc_model <= 32'd0;
    else if (branch) pc_model <= br_target;
    else if (!fetch_stall) pc_model <= pc_model + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; branch = 1'b0; wait_n = 0; force_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nstep();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd4);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fstall", {31'd0, fetch_stall}, 32'd1);
    reset = 1'b0;
    nstep();
    chk("n0_req", {31'd0, imem_req}, 32'd1);
    chk("n0_addr", imem_addr, 32'd0);
    chk("n0_valid", {31'd0, if_valid}, 32'd0);
    chk("n0_fstall", {31'd0, fetch_stall}, 32'd0);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      nstep();
      chk("zw_valid", {31'd0, if_valid}, 32'd1);
      chk("zw_pc", if_pc, 32'(4 * i));
      chk("zw_instr", if_instr, 32'(4 * i));
      chk("zw_pc4", if_pc4, 32'(4 * i + 4));
    end

    // 3 wait states starting with the request for 0x10
    wait_n = 3;
    for (int j = 0; j < 8; j++) begin
      nstep();
      chk("w3_valid", {31'd0, if_valid}, (j % 4 == 3) ? 32'd1 : 32'd0);
      chk("w3_addr", imem_addr, 32'(16 + 4 * ((j + 1) / 4)));
      chk("w3_fstall", {31'd0, fetch_stall}, (j % 4 == 2) ? 32'd0 : 32'd1);
      if (j % 4 == 3) chk("w3_pc", if_pc, 32'(16 + 4 * (j / 4)));
    end

    // ID stall with 0x10 held and 0x14 acked into the hold buffer
    do_reset();
    repeat (5) nstep();
    chk("st_pc10", if_pc, 32'h10);
    stall = 1'b1;
    #1;
    chk("st_capture_fstall", {31'd0, fetch_stall}, 32'd0);
    nstep();
    chk("st_full_req", {31'd0, imem_req}, 32'd0);
    chk("st_full_fstall", {31'd0, fetch_stall}, 32'd1);
    chk("st_full_pc", if_pc, 32'h10);
    nstep();
    chk("st_hold_pc7", if_pc, 32'h10);
    nstep();
    chk("st_hold_pc8", if_pc, 32'h10);
    nstep();
    chk("st_hold_pc9", if_pc, 32'h10);
    chk("st_hold_valid", {31'd0, if_valid}, 32'd1);
    stall = 1'b0;
    nstep();
    chk("st_rel_pc", if_pc, 32'h14);
    chk("st_rel_instr", if_instr, 32'h14);
    chk("st_rel_valid", {31'd0, if_valid}, 32'd1);
    nstep();
    chk("st_next_pc", if_pc, 32'h18);

    // branch while a 2-wait fetch of 0x20 is outstanding
    do_reset();
    repeat (8) nstep();
    chk("br_addr20", imem_addr, 32'h20);
    chk("br_pc1c", if_pc, 32'h1C);
    wait_n = 2;
    branch = 1'b1;
    br_target = 32'h100;
    #1;
    chk("br_fstall", {31'd0, fetch_stall}, 32'd1);
    nstep();
    branch = 1'b0;
    chk("br_valid9", {31'd0, if_valid}, 32'd0);
    chk("br_addr_stable", imem_addr, 32'h20);
    chk("br_req9", {31'd0, imem_req}, 32'd1);
    nstep();
    chk("br_sq_ack_fstall", {31'd0, fetch_stall}, 32'd1);
    chk("br_valid10", {31'd0, if_valid}, 32'd0);
    nstep();
    chk("br_addr100", imem_addr, 32'h100);
    chk("br_valid11", {31'd0, if_valid}, 32'd0);
    nstep();
    chk("br_valid12", {31'd0, if_valid}, 32'd0);
    nstep();
    chk("br_valid13", {31'd0, if_valid}, 32'd0);
    nstep();
    chk("br_tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("br_tgt_pc", if_pc, 32'h100);
    chk("br_tgt_instr", if_instr, 32'h100);
    chk("br_tgt_pc4", if_pc4, 32'h104);

    // branch together with stall while FULL, then wrap-around
    do_reset();
    repeat (5) nstep();
    stall = 1'b1;
    nstep();
    chk("bf_full_req", {31'd0, imem_req}, 32'd0);
    branch = 1'b1;
    br_target = 32'h200;
    nstep();
    branch = 1'b0;
    stall = 1'b0;
    chk("bf_valid", {31'd0, if_valid}, 32'd0);
    chk("bf_instr_nop", if_instr, 32'd0);
    chk("bf_addr", imem_addr, 32'h200);
    nstep();
    chk("bf_tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("bf_tgt_pc", if_pc, 32'h200);
    chk("bf_tgt_instr", if_instr, 32'h200);
    nstep();
    chk("bf_next_pc", if_pc, 32'h204);
    branch = 1'b1;
    br_target = 32'hFFFF_FFF8;
    nstep();
    branch = 1'b0;
    chk("wr_valid", {31'd0, if_valid}, 32'd0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFF8);
    nstep();
    chk("wr_pc_f8", if_pc, 32'hFFFF_FFF8);
    chk("wr_pc4_fc", if_pc4, 32'hFFFF_FFFC);
    nstep();
    chk("wr_pc_fc", if_pc, 32'hFFFF_FFFC);
    chk("wr_pc4_0", if_pc4, 32'd0);
    nstep();
    chk("wr_pc_0", if_pc, 32'd0);
    chk("wr_valid_0", {31'd0, if_valid}, 32'd1);

    // reset mid-request, then a late ack while IDLE
    do_reset();
    wait_n = 3;
    nstep();
    chk("rm_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    nstep();
    chk("rm_req_drop", {31'd0, imem_req}, 32'd0);
    chk("rm_valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b0;
    force_ack = 1'b1;
    #1;
    chk("rm_late_ack_fstall", {31'd0, fetch_stall}, 32'd1);
    nstep();
    force_ack = 1'b0;
    chk("rm_restart_req", {31'd0, imem_req}, 32'd1);
    chk("rm_restart_addr", imem_addr, 32'd0);
    chk("rm_restart_valid", {31'd0, if_valid}, 32'd0);
    wait_n = 0;
    nstep();
    chk("rm_first_valid", {31'd0, if_valid}, 32'd1);
    chk("rm_first_pc", if_pc, 32'd0);
    chk("rm_first_pc4", if_pc4, 32'd4);
    nstep();
    chk("rm_second_pc", if_pc, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
